// File: rtl/mdu_pkg.sv
// mdu_pkg: shared md_op encodings, FSM state type, divider latency and product helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_MADD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_e;

  // 32 iteration cycles + 1 sign-correction cycle
  localparam int unsigned DIV_CYCLES = 33;

  typedef logic [63:0] prod_t;

  // Low 64 bits of a 64x64 product equal the signed/unsigned 32x32 product
  function automatic prod_t mul64(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    prod_t ea;
    prod_t eb;
    ea = {{32{sgn & a[31]}}, a};
    eb = {{32{sgn & b[31]}}, b};
    return ea * eb;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: unsigned restoring divider, one quotient bit per cycle.
// Ports: clk, reset_n (async active-low), start (load operands),
//        dividend/divisor (unsigned), done (high during final step cycle),
//        quotient/remainder (valid from the cycle after done).
import mdu_pkg::*;

module mdu_div_core (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] dsr;
  logic [4:0]  cnt;
  logic        run;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] rem_sub;

  always_comb begin
    shifted = {remainder, quotient[31]};
    ge      = (shifted >= {1'b0, dsr});
    // when ge holds the difference is below dsr, so 32 bits suffice
    rem_sub = shifted[31:0] - dsr;
  end

  assign done = run && (cnt == 5'(DIV_CYCLES - 2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quotient  <= '0;
      remainder <= '0;
      dsr       <= '0;
      cnt       <= '0;
      run       <= 1'b0;
    end else if (start) begin
      quotient  <= dividend;
      remainder <= '0;
      dsr       <= divisor;
      cnt       <= '0;
      run       <= 1'b1;
    end else if (run) begin
      if (ge) begin
        remainder <= rem_sub;
        quotient  <= {quotient[30:0], 1'b1};
      end else begin
        remainder <= shifted[31:0];
        quotient  <= {quotient[30:0], 1'b0};
      end
      cnt <= cnt + 5'd1;
      if (done)
        run <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit holding architectural HI/LO.
// Ports: clk, reset_n (async active-low), md_op/md_start (operation issue),
//        rs_val/rt_val (operands), busy (operation in flight), hi/lo.
// Optional MDU_MADD_EN: enables op 7 (madd, {hi,lo} += signed rs*rt).
import mdu_pkg::*;

module mdu_iter #(
  parameter int unsigned MULT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  md_op,
  input  logic        md_start,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state;
  md_op_e      op;
  logic [3:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        mul_sgn;
  logic        neg_q;
  logic        neg_r;
  logic        dz_q;
`ifdef MDU_MADD_EN
  logic        madd_q;
`endif

  logic        accept;
  logic        div_go;
  logic        div_sgn;
  logic [31:0] dvd_mag;
  logic [31:0] dsr_mag;
  logic        div_done;
  logic [31:0] quo;
  logic [31:0] rem;
  prod_t       prod;

  always_comb begin
    op      = md_op_e'(md_op);
    accept  = md_start && (state == ST_IDLE) && !busy;
    div_sgn = (op == MD_DIV);
    div_go  = accept && ((op == MD_DIV) || (op == MD_DIVU));
    dvd_mag = (div_sgn && rs_val[31]) ? -rs_val : rs_val;
    dsr_mag = (div_sgn && rt_val[31]) ? -rt_val : rt_val;
    prod    = mul64(a_q, b_q, mul_sgn);
  end

  mdu_div_core u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_go),
    .dividend  (dvd_mag),
    .divisor   (dsr_mag),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mul_sgn <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_q    <= 1'b0;
`ifdef MDU_MADD_EN
      madd_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              MD_MULT, MD_MULTU: begin
                a_q     <= rs_val;
                b_q     <= rt_val;
                mul_sgn <= (op == MD_MULT);
`ifdef MDU_MADD_EN
                madd_q  <= 1'b0;
`endif
                cnt     <= 4'(MULT_CYCLES - 1);
                busy    <= 1'b1;
                state   <= ST_MUL;
              end
`ifdef MDU_MADD_EN
              MD_MADD: begin
                a_q     <= rs_val;
                b_q     <= rt_val;
                mul_sgn <= 1'b1;
                madd_q  <= 1'b1;
                cnt     <= 4'(MULT_CYCLES - 1);
                busy    <= 1'b1;
                state   <= ST_MUL;
              end
`else
              MD_MADD: ;
`endif
              MD_DIV, MD_DIVU: begin
                neg_q <= div_sgn && (rs_val[31] ^ rt_val[31]);
                neg_r <= div_sgn && rs_val[31];
                dz_q  <= (rt_val == '0);
                busy  <= 1'b1;
                state <= ST_DIV;
              end
              MD_MTHI: hi <= rs_val;
              MD_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (cnt == '0) begin
`ifdef MDU_MADD_EN
            {hi, lo} <= madd_q ? ({hi, lo} + prod) : prod;
`else
            {hi, lo} <= prod;
`endif
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DIV: begin
          if (div_done)
            state <= ST_FIX;
        end
        ST_FIX: begin
          if (!dz_q) begin
            lo <= neg_q ? -quo : quo;
            hi <= neg_r ? -rem : rem;
          end
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter. Stimulus pushes expected
// {hi, lo, busy cycles}; a monitor pops on each busy falling edge.
module tb_mdu_iter;

  logic        clk;
  logic        reset_n;
  logic [2:0]  md_op;
  logic        md_start;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  mdu_iter #(.MULT_CYCLES(5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .md_op    (md_op),
    .md_start (md_start),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    md_op    = 3'd0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: busy still %b after 100 cycles, required 0", name, busy);
    end
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                     input int ecyc);
    exp_t e;
    e.name = name;
    e.hi   = ehi;
    e.lo   = elo;
    e.cyc  = ecyc;
    sb.push_back(e);
    issue(op, a, b);
    wait_idle(name);
  endtask

  // Monitor: counts busy-high negedges, compares when busy drops.
  initial begin
    int   n;
    exp_t e;
    n = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        n = 0;
      end else if (busy) begin
        n++;
      end else if (n > 0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected completion: got busy pulse of %0d cycles, required none", n);
        end else begin
          e = sb.pop_front();
          chk({e.name, " hi"}, hi, e.hi);
          chk({e.name, " lo"}, lo, e.lo);
          chk({e.name, " busy cycles"}, 32'(n), 32'(e.cyc));
        end
        n = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    md_start = 1'b0;
    md_op    = 3'd0;
    rs_val   = '0;
    rt_val   = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    run("mult -1*2",      3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    run("multu ffff*2",   3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5);
    run("mult min*min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5);
    run("multu max*max",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
    run("div -7/2",       3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run("divu 7/2",       3'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 33);
    run("div -100/7",     3'd3, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2, 33);
    run("div 100/-7",     3'd3, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 33);

    issue(3'd5, 32'h00000011, 32'h0);
    chk("mthi hi", hi, 32'h00000011);
    chk("mthi busy", {31'd0, busy}, 32'd0);
    issue(3'd6, 32'h00000022, 32'h0);
    chk("mtlo lo", lo, 32'h00000022);
    chk("mtlo hi kept", hi, 32'h00000011);

    run("div x/0",        3'd3, 32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022, 33);
    run("divu x/0",       3'd4, 32'hFFFFFFFF, 32'h00000000, 32'h00000011, 32'h00000022, 33);
    run("div min/-1",     3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);

    // starts during busy must be ignored, including mthi
    begin
      exp_t e;
      e.name = "div 100/7 ignore";
      e.hi   = 32'h00000002;
      e.lo   = 32'h0000000E;
      e.cyc  = 33;
      sb.push_back(e);
      issue(3'd3, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      issue(3'd1, 32'd3, 32'd4);
      issue(3'd5, 32'hDEADBEEF, 32'h0);
      wait_idle("div 100/7 ignore");
    end

    // asynchronous reset mid-division
    issue(3'd3, 32'd50, 32'd3);
    repeat (9) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset busy", {31'd0, busy}, 32'd0);
    chk("async reset hi", hi, 32'h0);
    chk("async reset lo", lo, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(3'd6, 32'h00000005, 32'h0);
    chk("post-reset mtlo lo", lo, 32'h00000005);
    chk("post-reset busy", {31'd0, busy}, 32'd0);

    issue(3'd5, 32'h00000000, 32'h0);
    issue(3'd6, 32'hFFFFFFFF, 32'h0);
`ifdef MDU_MADD_EN
    run("madd 1*1",       3'd7, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000, 5);
    run("madd -1*1",      3'd7, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 5);
`else
    issue(3'd7, 32'h00000001, 32'h00000001);
    chk("op7 busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("op7 busy later", {31'd0, busy}, 32'd0);
    chk("op7 hi", hi, 32'h00000000);
    chk("op7 lo", lo, 32'hFFFFFFFF);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
